spectrum_hist_accum: RTL and testbench
======================================

# spectrum_hist_accum

Upstream stage of the bin-ratio preprocessing chain. It accumulates incoming detector events into a 1024-bin energy histogram held in internal RAM. After a programmed number of events it pulses `trans_start` to the preprocessing state machine and streams all 1024 bin counts in ascending order, clearing each bin as it is read. It then waits for `prepro_finished` before accepting the next spectrum.

## Interface
- `CNT_W`, 16: width of each bin counter and of `bin_dat`.
- `EVENT_TARGET`, 1000: events per spectrum; legal range 1 to 2^20−1.
- `clk` in 1: the single clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `event_valid` in 1: an event is presented.
- `event_bin` in 10: energy bin of the event, 0–1023.
- `event_ready` out 1: the block can accept an event; an event transfers when `event_valid && event_ready`.
- `trans_start` out 1: one-cycle pulse that starts the preprocessing state machine.
- `bin_dat` out CNT_W: streamed bin count.
- `bin_dat_addr` out 10: bin index of `bin_dat`.
- `bin_dat_valid` out 1: `bin_dat` and `bin_dat_addr` are valid.
- `prepro_finished` in 1: completion pulse from the preprocessing state machine.
- `spectrum_cnt` out 16: number of completed spectra; wraps at 65535 to 0.

## Operation
- Storage is a 1024×CNT_W RAM with one-cycle read latency and one write port.
- **CLEAR** (entered on reset)
  - Writes 0 to addresses 0..1023, one per cycle (1024 cycles).
  - `event_ready` is 0.
  - Moves to ACCUM after address 1023 is written.
- **ACCUM**
  - `event_ready` is 1 while the accepted-event counter is below `EVENT_TARGET`.
  - Update pipeline, two stages:
    - S0: accept the event and issue a RAM read of `event_bin`.
    - S1: compute count+1 and write it back.
  - Read-after-write hazard: if the S0 bin equals the bin being written in S1, S0 uses the S1 write data instead of the RAM output. Back-to-back events to the same bin must therefore each count.
  - When the counter reaches `EVENT_TARGET`, `event_ready` drops the next cycle. The block waits for S1 to drain (FLUSH, 2 cycles), then moves to DRAIN.
- **DRAIN**
  - `trans_start` is high for exactly the first DRAIN cycle.
  - Reads addresses 0..1023 on consecutive cycles and writes 0 to each address on the cycle its data is output (read-clear).
  - `bin_dat_valid` is high for exactly 1024 consecutive cycles, with no gaps.
  - Resets the event counter to 0.
  - Increments `spectrum_cnt` on the cycle address 1023 is output.
- **WAIT_DONE**
  - Waits for `prepro_finished`.
  - A `prepro_finished` pulse seen during DRAIN is latched and satisfies WAIT_DONE immediately.
  - Moves to ACCUM when both the drain is complete and finished has been seen.
- `event_valid` is ignored whenever `event_ready` is 0; those events are never counted.
- A `prepro_finished` pulse during ACCUM or CLEAR is ignored.
- `rst` asserted at any time, including mid-ACCUM or mid-DRAIN:
  - Aborts the operation.
  - Clears all counters and `spectrum_cnt`.
  - Re-enters CLEAR on the next cycle.

## Timing
- Reset values: `event_ready` 0, `trans_start` 0, `bin_dat` 0, `bin_dat_addr` 0, `bin_dat_valid` 0, `spectrum_cnt` 0.
- `event_ready` rises 1025 cycles after `rst` is released (1024 clear cycles plus the transition).
- Update latency: an accepted event is written 2 cycles after acceptance.
- Let T be the cycle the final (EVENT_TARGET-th) event is accepted:
  - `event_ready` is 0 from T+1.
  - `trans_start` pulses at T+3.
  - Bin 0 is valid at T+4; bin 1023 is valid at T+1027.
- `event_ready` reasserts the cycle after WAIT_DONE exits, at the earliest T+1028.

## Configuration
- `HIST_SAT_EN` defined:
  - Bin increments saturate at 2^CNT_W−1.
  - Further events to a saturated bin still count toward `EVENT_TARGET`.
- `HIST_SAT_EN` undefined: bin increments wrap modulo 2^CNT_W.

## Test plan
- **Reset clear:** release `rst`, hold `event_valid` high → `event_ready` rises at cycle 1025, and no event is counted before it.
- **Same-bin back-to-back:** EVENT_TARGET=8, 8 consecutive events to bin 5 → bin 5 streams as 8, every other bin as 0; `trans_start` occurs 3 cycles after the last accept.
- **Spread spectrum:** EVENT_TARGET=1024, one event per bin, random idle gaps → 1024 contiguous valid cycles with addresses 0..1023 in order, every count 1, `spectrum_cnt`=1.
- **Saturation:** CNT_W=4, EVENT_TARGET=20, all events to bin 0 → streams 15 with `HIST_SAT_EN` defined, 4 without it.
- **Read-clear and finish:** two spectra with `prepro_finished` pulsed mid-DRAIN during the first → the second spectrum's counts exclude the first spectrum's events; ACCUM resumes immediately after bin 1023; `spectrum_cnt`=2.
- **Reset mid-DRAIN:** assert `rst` at bin 300 → `bin_dat_valid` is 0 the next cycle, all RAM is re-cleared, and the next spectrum contains only new events.

Source files
------------

// File: rtl/spectrum_hist_accum.sv
// spectrum_hist_accum: 1024-bin event histogram with read-clear streaming drain
// Ports: clk, rst (sync, active-high); event_valid/event_bin/event_ready accept events;
// trans_start, bin_dat/bin_dat_addr/bin_dat_valid stream the spectrum; prepro_finished
// releases the next spectrum; spectrum_cnt counts completed spectra.
// Define HIST_SAT_EN to saturate bin counts instead of wrapping.
module spectrum_hist_accum #(
  parameter int CNT_W = 16,
  parameter int EVENT_TARGET = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_valid,
  input  logic [9:0]       event_bin,
  output logic             event_ready,
  output logic             trans_start,
  output logic [CNT_W-1:0] bin_dat,
  output logic [9:0]       bin_dat_addr,
  output logic             bin_dat_valid,
  input  logic             prepro_finished,
  output logic [15:0]      spectrum_cnt
);
  typedef enum logic [2:0] {CLEAR, ACCUM, FLUSH, DRAIN, WAIT_DONE} state_t;
  localparam logic [20:0] TARGET = 21'(EVENT_TARGET);
  state_t state;
  logic [9:0] addr, ra, wa, s1_bin;
  logic [20:0] ev_cnt, ev_cnt_nx;
  logic flush_cnt, fin_seen, s1_valid, s1_fwd, accept, we;
  logic [CNT_W-1:0] mem [0:1023];
  logic [CNT_W-1:0] ram_q, s1_fwd_dat, s1_base, wr_inc, wd;
  always_comb begin
    accept = event_valid && event_ready;
    ev_cnt_nx = ev_cnt + 21'(accept);
    // the RAM returns pre-write data when S0 reads the bin S1 is writing
    s1_base = s1_fwd ? s1_fwd_dat : ram_q;
`ifdef HIST_SAT_EN
    wr_inc = &s1_base ? s1_base : s1_base + CNT_W'(1);
`else
    wr_inc = s1_base + CNT_W'(1);
`endif
    ra = state == DRAIN ? addr : event_bin;
    we = state == CLEAR || s1_valid || bin_dat_valid;
    wa = state == CLEAR ? addr : s1_valid ? s1_bin : bin_dat_addr;
    wd = s1_valid ? wr_inc : '0;
  end
  assign bin_dat = bin_dat_valid ? ram_q : '0;
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    ram_q <= mem[ra];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      addr <= '0;
      ev_cnt <= '0;
      flush_cnt <= 1'b0;
      fin_seen <= 1'b0;
      s1_valid <= 1'b0;
      s1_fwd <= 1'b0;
      s1_bin <= '0;
      s1_fwd_dat <= '0;
      event_ready <= 1'b0;
      trans_start <= 1'b0;
      bin_dat_addr <= '0;
      bin_dat_valid <= 1'b0;
      spectrum_cnt <= '0;
    end else begin
      s1_valid <= accept;
      s1_bin <= event_bin;
      s1_fwd <= accept && s1_valid && s1_bin == event_bin;
      s1_fwd_dat <= wr_inc;
      trans_start <= 1'b0;
      bin_dat_valid <= state == DRAIN;
      if (state == DRAIN) bin_dat_addr <= addr;
      if (bin_dat_valid && &bin_dat_addr) spectrum_cnt <= spectrum_cnt + 16'd1;
      if (state == DRAIN && prepro_finished) fin_seen <= 1'b1;
      case (state)
        CLEAR: begin
          addr <= addr + 10'd1;
          if (&addr) state <= ACCUM;
        end
        ACCUM: begin
          ev_cnt <= ev_cnt_nx;
          event_ready <= ev_cnt_nx < TARGET;
          if (ev_cnt_nx == TARGET) begin
            state <= FLUSH;
            flush_cnt <= 1'b0;
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state <= DRAIN;
            trans_start <= 1'b1;
          end
        end
        DRAIN: begin
          addr <= addr + 10'd1;
          ev_cnt <= '0;
          if (&addr) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (fin_seen || prepro_finished) begin
            state <= ACCUM;
            event_ready <= 1'b1;
            fin_seen <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_spectrum_hist_accum.sv
// tb_spectrum_hist_accum: scoreboard bench with a bin-count reference model
module tb_spectrum_hist_accum;
  localparam int CW = 4;
  localparam int TGT = 1024;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic event_valid = 1'b0;
  logic prepro_finished = 1'b0;
  logic [9:0] event_bin = '0;
  logic event_ready, trans_start, bin_dat_valid;
  logic [CW-1:0] bin_dat;
  logic [9:0] bin_dat_addr;
  logic [15:0] spectrum_cnt;
  spectrum_hist_accum #(.CNT_W(CW), .EVENT_TARGET(TGT)) dut (
    .clk(clk), .rst(rst), .event_valid(event_valid), .event_bin(event_bin),
    .event_ready(event_ready), .trans_start(trans_start), .bin_dat(bin_dat),
    .bin_dat_addr(bin_dat_addr), .bin_dat_valid(bin_dat_valid),
    .prepro_finished(prepro_finished), .spectrum_cnt(spectrum_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {int a; int d;} exp_t;
  exp_t exp_q[$];
  int trans_q[$];
  int hist[1024];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_acc = 0;
  int spec_model = 0;
  int last_trans = -10;
  int last_valid = -10;
  bit drop_pend = 0;
  bit sc_pend = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask
  // model: every handshake adds one to its bin; a full spectrum is queued in address order
  always @(negedge clk) begin
    if (drop_pend) begin
      drop_pend = 0;
      chk(event_ready == 1'b0, "ready_drop", event_ready, 0);
    end
    if (event_valid === 1'b1 && event_ready === 1'b1 && !rst) begin
`ifdef HIST_SAT_EN
      hist[event_bin] = hist[event_bin] == MAXC ? MAXC : hist[event_bin] + 1;
`else
      hist[event_bin] = (hist[event_bin] + 1) % (MAXC + 1);
`endif
      n_acc++;
      if (n_acc == TGT) begin
        for (int a = 0; a < 1024; a++) begin
          exp_q.push_back('{a, hist[a]});
          hist[a] = 0;
        end
        trans_q.push_back(cyc + 3);
        n_acc = 0;
        drop_pend = 1;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    int t;
    int want;
    if (sc_pend) begin
      sc_pend = 0;
      chk(spectrum_cnt == 16'(spec_model), "spectrum_cnt", spectrum_cnt, spec_model);
    end
    if (trans_start === 1'b1) begin
      if (trans_q.size() == 0) chk(0, "trans_unexpected", 1, 0);
      else begin
        t = trans_q.pop_front();
        chk(cyc == t, "trans_cycle", cyc, t);
        last_trans = cyc;
      end
    end
    if (bin_dat_valid === 1'b1) begin
      if (exp_q.size() == 0) chk(0, "bin_unexpected", bin_dat_addr, -1);
      else begin
        e = exp_q.pop_front();
        chk(bin_dat_addr == 10'(e.a), "bin_addr", bin_dat_addr, e.a);
        chk(bin_dat == CW'(e.d), $sformatf("bin_dat[%0d]", e.a), bin_dat, e.d);
        want = e.a == 0 ? last_trans + 1 : last_valid + 1;
        chk(cyc == want, "bin_timing", cyc, want);
        if (e.a == 1023) begin
          spec_model++;
          sc_pend = 1;
        end
      end
      last_valid = cyc;
    end
  end
  task automatic send(input int b, input int gap);
    int t = 0;
    event_valid = 1'b1;
    event_bin = 10'(b);
    @(negedge clk);
    while (event_ready !== 1'b1) begin
      t++;
      if (t > 4000) begin
        errors++;
        $display("FAIL send_timeout: got no event_ready expected 1 at cycle %0d", cyc);
        summary();
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    event_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input int hold);
    int k;
    rst = 1'b1;
    event_valid = 1'b0;
    prepro_finished = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    exp_q.delete();
    trans_q.delete();
    foreach (hist[i]) hist[i] = 0;
    n_acc = 0;
    spec_model = 0;
    drop_pend = 0;
    sc_pend = 0;
    chk(event_ready == 1'b0, "rst_ready", event_ready, 0);
    chk(trans_start == 1'b0, "rst_trans", trans_start, 0);
    chk(bin_dat_valid == 1'b0, "rst_valid", bin_dat_valid, 0);
    chk(bin_dat == '0, "rst_dat", bin_dat, 0);
    chk(bin_dat_addr == '0, "rst_addr", bin_dat_addr, 0);
    chk(spectrum_cnt == '0, "rst_spectrum_cnt", spectrum_cnt, 0);
    event_valid = 1'b1;
    event_bin = 10'd5;
    rst = 1'b0;
    for (k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      if (event_ready) break;
    end
    chk(k == 1025, "ready_rise", k, 1025);
  endtask
  task automatic run_events(input int mode);
    int b;
    int g;
    for (int e = 0; e < TGT; e++) begin
      b = mode == 0 ? (e < 12 ? 5 : e) : mode == 1 ? e : mode == 2 ? 0 :
          (($urandom % 2) == 1 ? int'($urandom % 8) : int'($urandom % 1024));
      g = mode == 1 ? int'($urandom % 3) : (mode == 3 && ($urandom % 4) == 0) ? int'($urandom % 3) : 0;
      send(b, g);
    end
  endtask
  task automatic wait_bin(input int k);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bin_dat_valid === 1'b1 && bin_dat_addr == 10'(k)) && t < 4000);
    chk(t < 4000, "wait_bin", t, k);
  endtask
  task automatic wait_empty();
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (exp_q.size() != 0 && t < 4000);
    chk(t < 4000, "drain_done", t, 4000);
  endtask
  task automatic finish_spec(input bit mid, input int k);
    if (mid) begin
      wait_bin(k);
      prepro_finished = 1'b1;
      @(negedge clk);
      prepro_finished = 1'b0;
      wait_empty();
      chk(event_ready == 1'b1, "resume_mid", event_ready, 1);
    end else begin
      wait_empty();
      chk(event_ready == 1'b0, "hold_wait", event_ready, 0);
      repeat ($urandom % 4) begin
        @(posedge clk);
        #1;
      end
      prepro_finished = 1'b1;
      @(posedge clk);
      #1;
      prepro_finished = 1'b0;
      chk(event_ready == 1'b1, "resume_wait", event_ready, 1);
    end
  endtask
  initial begin
    do_reset(3);
    run_events(0);
    finish_spec(1'b0, 0);
    run_events(1);
    finish_spec(1'b1, 500);
    run_events(2);
    finish_spec(1'b1, int'($urandom % 1000));
    repeat (3) begin
      run_events(3);
      finish_spec(($urandom % 2) == 1, int'($urandom % 1000));
    end
    run_events(3);
    wait_bin(300);
    rst = 1'b1;
    do_reset(1);
    run_events(3);
    finish_spec(1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk(exp_q.size() == 0 && trans_q.size() == 0, "queues_empty", exp_q.size() + trans_q.size(), 0);
    summary();
    $finish;
  end
  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    summary();
    $fatal(1);
  end
endmodule
